ted_output_port_arbiter: RTL and testbench
==========================================

Name: ted_output_port_arbiter

Overview:
- Round-robin arbiter that shares the single 32-bit Avalon-MM output PIO among N hardware requesters, for example the encryption engine, the key loader and the debug path.
- Accepts one word at a time over valid/ready handshakes and issues a single-cycle Avalon write to PIO offset 0.
- Enforces a programmable hold gap after each write so external logic can sample every word.
- Has its own Avalon-MM CSR slave (0 wait states, 0 read latency) for enable, requester mask, hold length and status.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- HOLD_DEFAULT, 16'd4, reset value of the HOLD register (idle cycles after each PIO write).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*32  per-requester word; requester i occupies bits [32*i+31:32*i]
- req_ready  out  NUM_REQ  one-hot accept strobe
- pio_address  out  2  always 2'd0
- pio_chipselect  out  1  PIO write strobe
- pio_write_n  out  1  active-low write
- pio_writedata  out  32  word to PIO
- address  in  2  CSR word address
- chipselect  in  1  CSR select
- write_n  in  1  CSR active-low write
- writedata  in  32  CSR write data
- readdata  out  32  CSR read data, combinational from address
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- One clock domain: clk. reset_n is asynchronous, active-low.
- Reset values:
  - State IDLE; req_ready=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, pio_address=0, busy=0.
  - CTRL.enable=1, CTRL.mask=all ones, HOLD=HOLD_DEFAULT, last_grant=NUM_REQ-1 (so requester 0 has first priority), wcount=0, last_data=0.
- CSR map (writes need chipselect=1 and write_n=0):
  - 0 CTRL: bit0 enable; bits[8+NUM_REQ-1:8] mask. Read/write.
  - 1 HOLD: bits[15:0]. Read/write.
  - 2 STATUS: bit0 busy; bits[10:8] last_grant; bits[31:16] wcount. Read-only; writes ignored.
  - 3 LAST: last word written to the PIO. Read-only.
  - Unused bits read 0.
- Eligible set: elig = req_valid & mask, gated by enable.
- FSM:
  - IDLE: if elig != 0, select the first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap. That cycle: req_ready[g]=1 (combinational, one-hot), capture req_data[g], set last_grant=g, go to WRITE. Otherwise stay in IDLE with req_ready=0.
  - WRITE (exactly 1 cycle): pio_chipselect=1, pio_write_n=0, pio_writedata=captured word. At the end of the cycle: last_data<=word, wcount<=wcount+1 (16-bit wrap, 0xFFFF->0). Then go to HOLD if HOLD!=0, else IDLE.
  - HOLD: counter loaded with HOLD, decremented each cycle. Exit to IDLE after exactly HOLD cycles. Outputs idle.
- Latency:
  - Handshake cycle to PIO write: 1 cycle.
  - Minimum spacing between PIO writes: 2+HOLD cycles.
- Requesters must hold req_valid and req_data stable until accepted; requester behaviour without that guarantee is undefined.
- Boundary conditions:
  - enable cleared or mask changed mid-transaction: the current WRITE/HOLD completes. The new values apply only at the next IDLE arbitration.
  - HOLD written during HOLD: the running count is unaffected; the new value applies to the next hold.
  - Single eligible requester: it is granted back-to-back, every 2+HOLD cycles.
  - CSR write and arbitration in the same cycle: the arbitration uses the pre-write register values.
  - Reset mid-operation: any in-flight word is dropped, no partial PIO write is issued, and all state returns to reset values.
  - The PIO write strobe is never asserted in IDLE or HOLD.

Test Plan:
- Reset, then all 4 requesters valid with data 0x11111111..0x44444444, HOLD=4 → PIO writes in order req0,1,2,3, 6 cycles apart; STATUS.wcount=4; LAST=0x44444444.
- Only req2 valid continuously, HOLD=0 → req_ready[2] every 2nd cycle, PIO write every 2nd cycle, other ready bits stay 0.
- mask=4'b1010 with all requesters valid → only req1 and req3 granted, alternating; req0 and req2 never get ready.
- Clear enable in the cycle req1 is accepted → that word is still written and the hold completes, then no further grants; re-enable → arbitration resumes at req2.
- Preload wcount to 0xFFFF via 65535 writes (or force in sim), issue 1 more write → wcount=0x0000; a CSR write to STATUS leaves it unchanged.
- Assert reset_n low during HOLD after a write of 0xDEADBEEF → all outputs at reset values immediately; after release, req0 is granted first.

Source files
------------

// File: rtl/ted_output_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM output PIO among NUM_REQ requesters.
// Issues one single-cycle PIO write per grant, followed by a programmable idle gap.
module ted_output_port_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter logic [15:0] HOLD_DEFAULT = 16'd4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [1:0]            pio_address,
  output logic                  pio_chipselect,
  output logic                  pio_write_n,
  output logic [31:0]           pio_writedata,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_HOLD} state_t;

  state_t               state_reg, state_next;
  logic                 enable_reg;
  logic [NUM_REQ-1:0]   mask_reg;
  logic [15:0]          hold_reg;
  logic [15:0]          hold_cnt_reg;
  logic [2:0]           last_grant_reg;
  logic [15:0]          wcount_reg;
  logic [31:0]          last_data_reg;
  logic [31:0]          word_reg;

  logic [7:0]           elig_pad;
  logic [31:0]          req_word_pad [8];
  logic                 grant_found;
  logic [2:0]           grant_idx;
  logic [3:0]           probe;
  logic                 grant_valid;
  logic                 csr_we;
  logic                 unused_writedata;

  assign unused_writedata = ^writedata[31:16];
  assign csr_we           = chipselect & ~write_n;
  assign elig_pad         = 8'(req_valid & mask_reg & {NUM_REQ{enable_reg}});
  assign busy             = (state_reg != ST_IDLE);
  assign pio_address      = 2'd0;

  // Words and ready strobes are padded to 8 lanes so a 3-bit grant index fits any NUM_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      if (gi < NUM_REQ) begin : g_used
        assign req_word_pad[gi] = req_data[32*gi +: 32];
        assign req_ready[gi]    = grant_valid && (grant_idx == 3'(gi));
      end else begin : g_pad
        assign req_word_pad[gi] = '0;
      end
    end
  endgenerate

  // Search starts just after the previous winner and wraps at NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_grant_reg;
    probe       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe = {1'b0, last_grant_reg} + 4'(k);
      if (probe >= 4'(NUM_REQ)) probe = probe - 4'(NUM_REQ);
      if (!grant_found && elig_pad[probe[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = probe[2:0];
      end
    end
  end

  assign grant_valid = reset_n && (state_reg == ST_IDLE) && grant_found;

  always_comb begin
    state_next     = state_reg;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = word_reg;
        state_next     = (hold_reg != 16'd0) ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        if (hold_cnt_reg == 16'd1) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      enable_reg     <= 1'b1;
      mask_reg       <= '1;
      hold_reg       <= HOLD_DEFAULT;
      hold_cnt_reg   <= '0;
      last_grant_reg <= 3'(NUM_REQ - 1);
      wcount_reg     <= '0;
      last_data_reg  <= '0;
      word_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (grant_valid) begin
        word_reg       <= req_word_pad[grant_idx];
        last_grant_reg <= grant_idx;
      end
      // The gap length is latched here, so later HOLD writes only affect the next gap.
      if (state_reg == ST_WRITE) begin
        last_data_reg <= word_reg;
        wcount_reg    <= wcount_reg + 16'd1;
        hold_cnt_reg  <= hold_reg;
      end else if (state_reg == ST_HOLD) begin
        hold_cnt_reg  <= hold_cnt_reg - 16'd1;
      end
      if (csr_we) begin
        case (address)
          2'd0: begin
            enable_reg <= writedata[0];
            mask_reg   <= writedata[8 +: NUM_REQ];
          end
          2'd1:    hold_reg <= writedata[15:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0]             = enable_reg;
        readdata[8 +: NUM_REQ]  = mask_reg;
      end
      2'd1: readdata[15:0] = hold_reg;
      2'd2: begin
        readdata[0]     = busy;
        readdata[10:8]  = last_grant_reg;
        readdata[31:16] = wcount_reg;
      end
      default: readdata = last_data_reg;
    endcase
  end

endmodule

// File: tb/tb_ted_output_port_arbiter.sv
// Directed bench for ted_output_port_arbiter: a cycle-level reference model checked
// every cycle, plus literal expectations per scenario.
module tb_ted_output_port_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     pio_address;
  logic           pio_chipselect, pio_write_n;
  logic [31:0]    pio_writedata;
  logic [1:0]     address = 2'd0;
  logic           chipselect = 1'b0;
  logic           write_n = 1'b1;
  logic [31:0]    writedata = '0;
  logic [31:0]    readdata;
  logic           busy;

  always #5 clk = ~clk;

  ted_output_port_arbiter #(.NUM_REQ(N), .HOLD_DEFAULT(16'd4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a pending write flag plus an idle-gap countdown.
  logic        m_write_now;
  logic [31:0] m_word;
  int          m_gap;
  int          m_lg;
  logic [15:0] m_wcount;
  logic [31:0] m_last;
  logic        m_en;
  logic [N-1:0] m_mask;
  logic [15:0] m_hold;

  task automatic model_reset();
    m_write_now = 1'b0; m_word = '0; m_gap = 0; m_lg = N - 1;
    m_wcount = '0; m_last = '0; m_en = 1'b1; m_mask = '1; m_hold = 16'd4;
  endtask

  // Observation logs and source state shared with the stimulus.
  int          cyc = 0;
  int          wr_cyc[$];
  logic [31:0] wr_dat[$];
  int          grant_q[$];
  logic [N-1:0] ready_or = '0;
  logic [N-1:0] acc = '0;
  int          src_cnt[N];
  logic [31:0] src_data[N];

  initial begin
    model_reset();
    for (int i = 0; i < N; i++) begin src_cnt[i] = 0; src_data[i] = '0; end
  end

  // Compare process: mid-cycle, inputs and state are stable.
  initial begin : compare
    logic        e_busy;
    logic [N-1:0] e_ready;
    logic [31:0] e_rd;
    logic [15:0] old_hold;
    int          g;
    int          idx;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) model_reset();
      e_busy  = m_write_now || (m_gap > 0);
      e_ready = '0;
      g       = -1;
      if (!e_busy && reset_n && m_en) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_lg + k) % N;
          if (g < 0 && req_valid[idx] && m_mask[idx]) g = idx;
        end
      end
      if (g >= 0) e_ready[g] = 1'b1;
      case (address)
        2'd0:    e_rd = {20'd0, m_mask, 7'd0, m_en};
        2'd1:    e_rd = {16'd0, m_hold};
        2'd2:    e_rd = {m_wcount, 5'd0, 3'(m_lg), 7'd0, e_busy};
        default: e_rd = m_last;
      endcase
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("pio_chipselect", 32'(pio_chipselect), 32'(m_write_now));
      check("pio_write_n", 32'(pio_write_n), 32'(!m_write_now));
      check("pio_writedata", pio_writedata, m_write_now ? m_word : 32'd0);
      check("pio_address", 32'(pio_address), 32'd0);
      check("busy", 32'(busy), 32'(e_busy));
      check("readdata", readdata, e_rd);

      if (pio_chipselect && !pio_write_n) begin
        wr_cyc.push_back(cyc);
        wr_dat.push_back(pio_writedata);
        $display("cycle %0d: pio write %h", cyc, pio_writedata);
      end
      for (int i = 0; i < N; i++) if (req_ready[i]) grant_q.push_back(i);
      ready_or = ready_or | req_ready;
      acc      = req_ready;

      if (reset_n) begin
        old_hold = m_hold;
        if (chipselect && !write_n) begin
          if (address == 2'd0) begin m_en = writedata[0]; m_mask = writedata[8 +: N]; end
          if (address == 2'd1) m_hold = writedata[15:0];
        end
        if (m_write_now) begin
          m_last = m_word; m_wcount = m_wcount + 16'd1;
          m_write_now = 1'b0; m_gap = int'(old_hold);
        end else if (m_gap > 0) begin
          m_gap--;
        end else if (g >= 0) begin
          m_write_now = 1'b1; m_word = req_data[32*g +: 32]; m_lg = g;
        end
      end
    end
  end

  // Requester driver: each source offers src_cnt words, bumping the data after each accept.
  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && src_cnt[i] > 0) begin
          src_cnt[i]--;
          src_data[i] = src_data[i] + 32'd1;
        end
        req_valid[i] = (src_cnt[i] > 0);
        req_data[32*i +: 32] = src_data[i];
      end
    end
  end

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    address = a;
    @(negedge clk); #1;
    d = readdata;
  endtask

  task automatic clear_logs();
    wr_cyc.delete(); wr_dat.delete(); grant_q.delete(); ready_or = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset_n = 1'b0;
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic load_src(input int i, input int cnt, input logic [31:0] d);
    src_cnt[i] = cnt; src_data[i] = d;
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wr_dat.size() < n && k < budget) begin
      @(negedge clk); #1; k++;
    end
    if (wr_dat.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL wait_writes: got %0d writes required %0d", wr_dat.size(), n);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : main
    logic [31:0] d;
    int bad, c1, c3, k;

    // Reset values of the CSRs.
    do_reset();
    csr_read(2'd0, d); check("reset_ctrl", d, 32'h0000_0F01);
    csr_read(2'd1, d); check("reset_hold", d, 32'h0000_0004);
    csr_read(2'd2, d); check("reset_status", d, 32'h0000_0300);
    csr_read(2'd3, d); check("reset_last", d, 32'h0000_0000);

    // All four requesters, HOLD=4: order 0..3, six cycles apart.
    do_reset();
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) load_src(i, 1, 32'h1111_1111 * (i + 1));
    wait_writes(4, 100);
    if (wr_dat.size() >= 4) begin
      check("t1_word0", wr_dat[0], 32'h1111_1111);
      check("t1_word1", wr_dat[1], 32'h2222_2222);
      check("t1_word2", wr_dat[2], 32'h3333_3333);
      check("t1_word3", wr_dat[3], 32'h4444_4444);
      for (int j = 0; j < 3; j++) check("t1_spacing", 32'(wr_cyc[j+1] - wr_cyc[j]), 32'd6);
    end
    run_cycles(8);
    csr_read(2'd2, d); check("t1_wcount", {16'd0, d[31:16]}, 32'd4);
    csr_read(2'd3, d); check("t1_last", d, 32'h4444_4444);

    // Single requester 2, HOLD=0: a grant every second cycle.
    do_reset();
    csr_write(2'd1, 32'd0);
    @(negedge clk); #1;
    clear_logs();
    load_src(2, 1000, 32'hA5A5_0000);
    run_cycles(40);
    src_cnt[2] = 0;
    check("t2_other_ready", 32'(ready_or & 4'b1011), 32'd0);
    check("t2_write_count_ok", 32'(wr_dat.size() >= 18), 32'd1);
    bad = 0;
    for (int j = 0; j + 1 < wr_cyc.size(); j++) if (wr_cyc[j+1] - wr_cyc[j] != 2) bad++;
    check("t2_spacing_bad", 32'(bad), 32'd0);
    if (wr_dat.size() >= 2) begin
      check("t2_word0", wr_dat[0], 32'hA5A5_0000);
      check("t2_word1", wr_dat[1], 32'hA5A5_0001);
    end

    // Mask 1010: only requesters 1 and 3, alternating.
    do_reset();
    csr_write(2'd1, 32'd1);
    csr_write(2'd0, 32'h0000_0A01);
    @(negedge clk); #1;
    clear_logs();
    for (int i = 0; i < N; i++) load_src(i, 100, 32'h1000_0000 * (i + 1));
    run_cycles(40);
    for (int i = 0; i < N; i++) src_cnt[i] = 0;
    check("t3_ready0_never", 32'(ready_or[0]), 32'd0);
    check("t3_ready2_never", 32'(ready_or[2]), 32'd0);
    c1 = 0; c3 = 0; bad = 0;
    foreach (grant_q[j]) begin
      if (grant_q[j] == 1) c1++;
      if (grant_q[j] == 3) c3++;
      if (j > 0 && grant_q[j] == grant_q[j-1]) bad++;
    end
    check("t3_both_granted", 32'(c1 >= 5 && c3 >= 5), 32'd1);
    check("t3_alternation_bad", 32'(bad), 32'd0);

    // Disable in the cycle req1 is accepted, then re-enable.
    do_reset();
    @(negedge clk); #1;
    for (int i = 0; i < N; i++) load_src(i, 1, 32'h1111_1111 * (i + 1));
    k = 0;
    while (req_ready[0] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (req_ready[0] !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL t4_wait_ready0: got %b required 1", req_ready[0]);
    end
    repeat (5) @(posedge clk);
    csr_write(2'd0, 32'h0000_0F00);
    run_cycles(30);
    check("t4_writes_while_disabled", 32'(wr_dat.size()), 32'd2);
    if (wr_dat.size() >= 2) check("t4_req1_word", wr_dat[1], 32'h2222_2222);
    check("t4_idle", 32'(busy), 32'd0);
    csr_write(2'd0, 32'h0000_0F01);
    wait_writes(3, 30);
    if (wr_dat.size() >= 3) check("t4_resume_req2", wr_dat[2], 32'h3333_3333);

    // wcount wrap from 0xFFFF, and STATUS is read-only.
    do_reset();
    csr_write(2'd1, 32'd0);
    address = 2'd2;
    run_cycles(2);
    force dut.wcount_reg = 16'hFFFF;
    m_wcount = 16'hFFFF;
    #2;
    release dut.wcount_reg;
    csr_read(2'd2, d); check("t5_preload", {16'd0, d[31:16]}, 32'h0000_FFFF);
    @(negedge clk); #1;
    load_src(0, 1, 32'h0BAD_F00D);
    wait_writes(1, 20);
    run_cycles(2);
    csr_read(2'd2, d); check("t5_wrap", {16'd0, d[31:16]}, 32'd0);
    csr_write(2'd2, 32'hFFFF_FFFF);
    csr_read(2'd2, d); check("t5_status_ro", {16'd0, d[31:16]}, 32'd0);
    csr_read(2'd3, d); check("t5_last", d, 32'h0BAD_F00D);

    // Reset asserted during the hold after writing 0xDEADBEEF.
    do_reset();
    @(negedge clk); #1;
    load_src(0, 1, 32'hDEAD_BEEF);
    wait_writes(1, 20);
    if (wr_dat.size() >= 1) check("t6_word", wr_dat[0], 32'hDEAD_BEEF);
    @(posedge clk); #3;
    address = 2'd3;
    for (int i = 0; i < N; i++) load_src(i, 1, 32'h5000_0000 + 32'(i));
    reset_n = 1'b0;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_cs", 32'(pio_chipselect), 32'd0);
    check("t6_rst_write_n", 32'(pio_write_n), 32'd1);
    check("t6_rst_wdata", pio_writedata, 32'd0);
    check("t6_rst_ready", 32'(req_ready), 32'd0);
    check("t6_rst_last", readdata, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    clear_logs();
    reset_n = 1'b1;
    wait_writes(1, 20);
    if (wr_dat.size() >= 1) check("t6_first_after_reset", wr_dat[0], 32'h5000_0000);
    if (grant_q.size() >= 1) check("t6_first_grant", 32'(grant_q[0]), 32'd0);
    run_cycles(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
